// File: rtl/mdio_slave.sv
// Clause 22 MDIO responder. Oversamples MDC/MDIO in the clk domain, decodes frames,
// issues register write/read strobes and serialises read data back onto MDIO.
module mdio_slave #(
  parameter logic [4:0] PHY_ADDR     = 5'd1,
  parameter int         PREAMBLE_MIN = 32,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_mdc,
  inout  wire         io_mdio,
  output logic [4:0]  o_reg_addr,
  output logic        o_wr_en,
  output logic [15:0] o_wr_data,
  output logic        o_rd_en,
  input  logic [15:0] i_rd_data,
  output logic        o_busy,
  output logic        o_frame_err,
  output logic        o_mdio_oe,
  output logic [2:0]  o_dbg_state
);
  localparam int            PW      = $clog2(PREAMBLE_MIN + 1);
  localparam logic [PW-1:0] PRE_MIN = PW'(PREAMBLE_MIN);

  typedef enum logic [2:0] {IDLE, ST2, OP, PHYAD, REGAD, TA, DATA} state_t;
  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_mdc_sync, r_mdio_sync;
  logic                   r_mdc_prev;
  logic                   w_mdc, w_bit, w_rise, w_fall, w_err;
  logic [PW-1:0]          r_pre_cnt;
  logic [3:0]             r_bit_cnt;
  logic [14:0]            r_shift;
  logic [15:0]            w_shift_nxt, r_tx;
  logic                   r_is_read, r_match, r_rd_load, r_oe, r_out;
  logic [4:0]             r_reg_addr;
  logic [15:0]            r_wr_data;
  logic                   r_wr_en, r_rd_en, r_busy, r_frame_err;

  assign w_mdc       = r_mdc_sync[SYNC_STAGES-1];
  assign w_bit       = r_mdio_sync[SYNC_STAGES-1];
  assign w_rise      = w_mdc & ~r_mdc_prev;
  assign w_fall      = ~w_mdc & r_mdc_prev;
  assign w_shift_nxt = {r_shift, w_bit};

  assign io_mdio     = r_oe ? r_out : 1'bz;
  assign o_mdio_oe   = r_oe;
  assign o_reg_addr  = r_reg_addr;
  assign o_wr_en     = r_wr_en;
  assign o_wr_data   = r_wr_data;
  assign o_rd_en     = r_rd_en;
  assign o_busy      = r_busy;
  assign o_frame_err = r_frame_err;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mdc_sync  <= '0;
      r_mdio_sync <= '0;
      r_mdc_prev  <= 1'b0;
    end else begin
      r_mdc_sync  <= {r_mdc_sync[SYNC_STAGES-2:0], i_mdc};
      r_mdio_sync <= {r_mdio_sync[SYNC_STAGES-2:0], io_mdio};
      r_mdc_prev  <= w_mdc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // The state only advances on a detected MDC rise; every field ends on its last bit.
  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    if (w_rise) begin
      unique case (r_state)
        IDLE:  if (!w_bit && r_pre_cnt >= PRE_MIN) w_state_nxt = ST2;
        ST2:   if (w_bit) w_state_nxt = OP;
               else begin w_err = 1'b1; w_state_nxt = IDLE; end
        OP:    if (r_bit_cnt == 4'd1) begin
                 if (w_shift_nxt[1:0] == 2'b10 || w_shift_nxt[1:0] == 2'b01) w_state_nxt = PHYAD;
                 else begin w_err = 1'b1; w_state_nxt = IDLE; end
               end
        PHYAD: if (r_bit_cnt == 4'd4) w_state_nxt = REGAD;
        REGAD: if (r_bit_cnt == 4'd4) w_state_nxt = TA;
        TA:    if (!r_is_read && (w_bit != (r_bit_cnt == 4'd0))) begin
                 w_err = 1'b1; w_state_nxt = IDLE;
               end else if (r_bit_cnt == 4'd1) w_state_nxt = DATA;
        DATA:  if (r_bit_cnt == 4'd15) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_tx        <= '0;
      r_is_read   <= 1'b0;
      r_match     <= 1'b0;
      r_rd_load   <= 1'b0;
      r_oe        <= 1'b0;
      r_out       <= 1'b0;
      r_reg_addr  <= '0;
      r_wr_data   <= '0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_frame_err <= w_err;
      r_rd_load   <= r_rd_en;
      if (r_rd_load) r_tx <= i_rd_data;
      if (w_rise) begin
        r_shift   <= w_shift_nxt[14:0];
        r_bit_cnt <= (w_state_nxt != r_state || r_state == IDLE) ? 4'd0 : r_bit_cnt + 4'd1;
        unique case (r_state)
          IDLE: begin
            if (w_bit) begin
              if (r_pre_cnt < PRE_MIN) r_pre_cnt <= r_pre_cnt + PW'(1);
            end else if (r_pre_cnt >= PRE_MIN) r_busy <= 1'b1;
            else r_pre_cnt <= '0;
          end
          OP:    if (r_bit_cnt == 4'd1) r_is_read <= (w_shift_nxt[1:0] == 2'b10);
          PHYAD: if (r_bit_cnt == 4'd4) r_match <= (w_shift_nxt[4:0] == PHY_ADDR);
          REGAD: if (r_bit_cnt == 4'd4 && r_match) begin
                   r_reg_addr <= w_shift_nxt[4:0];
                   r_rd_en    <= r_is_read;
                 end
          DATA:  if (r_bit_cnt == 4'd15 && !r_is_read) begin
                   r_wr_data <= w_shift_nxt;
                   r_wr_en   <= r_match;
                 end
          default: ;
        endcase
        if (r_state != IDLE && w_state_nxt == IDLE) begin
          r_busy    <= 1'b0;
          r_pre_cnt <= '0;
        end
      end
      // Drive 0 on the fall after TA1, then one data bit per fall; any other fall releases.
      if (w_fall) begin
        if (r_is_read && r_match && r_state == TA && r_bit_cnt == 4'd1) begin
          r_oe  <= 1'b1;
          r_out <= 1'b0;
        end else if (r_is_read && r_match && r_state == DATA) begin
          r_oe  <= 1'b1;
          r_out <= r_tx[15];
          r_tx  <= {r_tx[14:0], 1'b0};
        end else begin
          r_oe  <= 1'b0;
          r_out <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mdio_slave.sv
// Directed bench for mdio_slave: acts as the MDIO master, bit-bangs Clause 22 frames
// and checks strobes, decoded fields and the read data returned on MDIO.
module tb_mdio_slave;
  logic        clk = 1'b0;
  logic        rst;
  logic        mdc;
  logic        tb_oe, tb_val;
  wire         mdio;
  logic [4:0]  reg_addr;
  logic        wr_en, rd_en, busy, frame_err, mdio_oe;
  logic [15:0] wr_data, rd_data;
  logic [2:0]  dbg_state;

  int tests = 0;
  int fails = 0;
  int cnt_wr = 0, cnt_rd = 0, cnt_err = 0, cnt_oe = 0, cnt_busy = 0;
  logic       busy_q = 1'b0;
  logic [4:0] rd_addr_seen = '0;
  logic       s_oe, s_mdio;
  int b_wr, b_rd, b_err, b_oe, b_busy;

  assign mdio = tb_oe ? tb_val : 1'bz;

  always #5 clk = ~clk;

  mdio_slave #(.PHY_ADDR(5'd1), .PREAMBLE_MIN(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .i_mdc(mdc), .io_mdio(mdio),
    .o_reg_addr(reg_addr), .o_wr_en(wr_en), .o_wr_data(wr_data),
    .o_rd_en(rd_en), .i_rd_data(rd_data), .o_busy(busy),
    .o_frame_err(frame_err), .o_mdio_oe(mdio_oe), .o_dbg_state(dbg_state)
  );

  always @(posedge clk) begin
    cnt_wr  <= cnt_wr + int'(wr_en);
    cnt_rd  <= cnt_rd + int'(rd_en);
    cnt_err <= cnt_err + int'(frame_err);
    cnt_oe  <= cnt_oe + int'(mdio_oe);
    busy_q  <= busy;
    if (busy && !busy_q) cnt_busy <= cnt_busy + 1;
    if (rd_en) rd_addr_seen <= reg_addr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_wr = cnt_wr; b_rd = cnt_rd; b_err = cnt_err; b_oe = cnt_oe; b_busy = cnt_busy;
  endtask

  // One MDC period: low half with the new bit, sample DUT drive, then high half.
  task automatic clock_bit(input logic drv, input logic val);
    tb_oe = drv; tb_val = val;
    repeat (6) @(negedge clk);
    s_oe = mdio_oe; s_mdio = mdio;
    mdc = 1'b1;
    repeat (6) @(negedge clk);
    mdc = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) clock_bit(1'b1, v[i]);
  endtask

  task automatic preamble(input int n);
    for (int i = 0; i < n; i++) clock_bit(1'b1, 1'b1);
  endtask

  task automatic write_frame(input int pre, input logic [4:0] phy, input logic [4:0] ra,
                             input logic [1:0] ta, input logic [15:0] d);
    preamble(pre);
    send_bits({2'b01, 2'b01, phy, ra, ta}, 16);
    send_bits(d, 16);
    tb_oe = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    logic [15:0] exp_d;
    rst = 1'b1; mdc = 1'b0; tb_oe = 1'b0; tb_val = 1'b1; rd_data = '0;
    repeat (5) @(negedge clk);
    check("reset_wr_en",     32'(wr_en), 0);
    check("reset_rd_en",     32'(rd_en), 0);
    check("reset_busy",      32'(busy), 0);
    check("reset_frame_err", 32'(frame_err), 0);
    check("reset_reg_addr",  32'(reg_addr), 0);
    check("reset_wr_data",   32'(wr_data), 0);
    check("reset_mdio_oe",   32'(mdio_oe), 0);
    check("reset_state",     32'(dbg_state), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Write 0xBEEF to reg 5 of phy 1
    snap();
    write_frame(32, 5'd1, 5'd5, 2'b10, 16'hBEEF);
    check("w1_wr_pulses", 32'(cnt_wr - b_wr), 1);
    check("w1_reg_addr",  32'(reg_addr), 5);
    check("w1_wr_data",   32'(wr_data), 32'hBEEF);
    check("w1_busy_low",  32'(busy), 0);
    check("w1_busy_seen", 32'(cnt_busy - b_busy), 1);
    check("w1_no_drive",  32'(cnt_oe - b_oe), 0);
    check("w1_no_err",    32'(cnt_err - b_err), 0);

    // Read reg 3 returning 0xA5C3
    snap();
    rd_data = 16'hA5C3;
    exp_d = 16'hA5C3;
    preamble(32);
    send_bits({2'b01, 2'b10, 5'd1, 5'd3}, 14);
    clock_bit(1'b0, 1'b0);
    check("r_ta1_z", 32'(s_oe), 0);
    clock_bit(1'b0, 1'b0);
    check("r_ta2_zero", 32'({s_oe, s_mdio}), 32'b10);
    for (int i = 15; i >= 0; i--) begin
      clock_bit(1'b0, 1'b0);
      check($sformatf("r_data_bit%0d", i), 32'({s_oe, s_mdio}), 32'({1'b1, exp_d[i]}));
    end
    clock_bit(1'b0, 1'b0);
    check("r_release", 32'(s_oe), 0);
    repeat (10) @(negedge clk);
    check("r_rd_pulses",  32'(cnt_rd - b_rd), 1);
    check("r_rd_addr",    32'(rd_addr_seen), 3);
    check("r_no_wr",      32'(cnt_wr - b_wr), 0);
    check("r_busy_low",   32'(busy), 0);

    // Write addressed to phy 7 is ignored, then phy 1 still decodes
    snap();
    write_frame(32, 5'd7, 5'd4, 2'b10, 16'h1111);
    check("m_no_wr",  32'(cnt_wr - b_wr), 0);
    check("m_no_rd",  32'(cnt_rd - b_rd), 0);
    check("m_no_err", 32'(cnt_err - b_err), 0);
    check("m_no_oe",  32'(cnt_oe - b_oe), 0);
    check("m_reg_addr_kept", 32'(reg_addr), 3);
    snap();
    write_frame(32, 5'd1, 5'd9, 2'b10, 16'h1234);
    check("m2_wr_pulses", 32'(cnt_wr - b_wr), 1);
    check("m2_wr_data",   32'(wr_data), 32'h1234);
    check("m2_reg_addr",  32'(reg_addr), 9);

    // 31-bit preamble rejected, 32-bit accepted
    snap();
    write_frame(31, 5'd1, 5'd2, 2'b10, 16'hCAFE);
    check("p31_no_busy", 32'(cnt_busy - b_busy), 0);
    check("p31_no_wr",   32'(cnt_wr - b_wr), 0);
    check("p31_reg_addr", 32'(reg_addr), 9);
    snap();
    write_frame(32, 5'd1, 5'd2, 2'b10, 16'hCAFE);
    check("p32_wr_pulses", 32'(cnt_wr - b_wr), 1);
    check("p32_wr_data",   32'(wr_data), 32'hCAFE);
    check("p32_reg_addr",  32'(reg_addr), 2);

    // Bad turnaround and illegal opcode
    snap();
    preamble(32);
    send_bits({2'b01, 2'b01, 5'd1, 5'd6, 2'b11}, 16);
    tb_oe = 1'b0;
    repeat (10) @(negedge clk);
    check("ta_err_pulses", 32'(cnt_err - b_err), 1);
    check("ta_no_wr",      32'(cnt_wr - b_wr), 0);
    check("ta_state_idle", 32'(dbg_state), 0);
    check("ta_busy_low",   32'(busy), 0);
    snap();
    preamble(32);
    send_bits({12'd0, 2'b01, 2'b11}, 4);
    tb_oe = 1'b0;
    repeat (10) @(negedge clk);
    check("op_err_pulses", 32'(cnt_err - b_err), 1);
    check("op_state_idle", 32'(dbg_state), 0);

    // Reset while read data bit 8 is on the wire
    snap();
    rd_data = 16'h5A5A;
    preamble(32);
    send_bits({2'b01, 2'b10, 5'd1, 5'd4}, 14);
    clock_bit(1'b0, 1'b0);
    clock_bit(1'b0, 1'b0);
    for (int i = 15; i >= 9; i--) clock_bit(1'b0, 1'b0);
    repeat (6) @(negedge clk);
    check("rr_bit8_driven", 32'({mdio_oe, mdio}), 32'b10);
    rst = 1'b1;
    #1;
    check("rr_oe",        32'(mdio_oe), 0);
    check("rr_busy",      32'(busy), 0);
    check("rr_reg_addr",  32'(reg_addr), 0);
    check("rr_wr_data",   32'(wr_data), 0);
    check("rr_strobes",   32'({wr_en, rd_en, frame_err}), 0);
    check("rr_state",     32'(dbg_state), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rr_no_wr", 32'(cnt_wr - b_wr), 0);
    snap();
    write_frame(32, 5'd1, 5'd17, 2'b10, 16'h8001);
    check("rr2_wr_pulses", 32'(cnt_wr - b_wr), 1);
    check("rr2_wr_data",   32'(wr_data), 32'h8001);
    check("rr2_reg_addr",  32'(reg_addr), 17);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
